// File: rtl/icestick_pkg.sv
// icestick_pkg -- shared definitions for the iCEstick switch-input slice.
//
// Contents:
//   LOW, RISE_CHK, HIGH, FALL_CHK  debounce FSM state encoding (2 bits)
//   DEFAULT_DEBOUNCE_CYCLES        10 ms qualification window at 12 MHz
//   cnt_width()                    counter width helper, never below 1 bit
package icestick_pkg;

  // Bit 1 of the encoding is set exactly in the two states where the
  // debounced level is high (HIGH and FALL_CHK).
  localparam logic [1:0] LOW      = 2'd0;
  localparam logic [1:0] RISE_CHK = 2'd1;
  localparam logic [1:0] HIGH     = 2'd2;
  localparam logic [1:0] FALL_CHK = 2'd3;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 120000;

  // Width needed to hold 0..n-1, with a floor of one bit so that small
  // terminal counts still give a legal vector.
  function automatic int cnt_width(input int n);
    if (n < 3) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/sw_debounce_chan.sv
// sw_debounce_chan -- one switch channel: two-flop synchroniser, debounce
// FSM with qualification counter, and registered level/press/release.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   sw_raw      raw asynchronous switch pin, 1 = pressed
//   sw_level    debounced level
//   sw_press    one-cycle pulse on an accepted press (and on auto-repeat)
//   sw_release  one-cycle pulse on an accepted release
//
// Build option: define SW_DEBOUNCE_REPEAT_EN to add auto-repeat press
// pulses while the switch is held (REPEAT_DELAY, then every REPEAT_PERIOD).
module sw_debounce_chan
  import icestick_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = 6000000,
  parameter int REPEAT_PERIOD   = 1200000
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_raw,
  output logic sw_level,
  output logic sw_press,
  output logic sw_release
);

  localparam int             CW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          press_nxt;
  logic          release_nxt;
  logic          rep_fire;

  // Qualification FSM. A reversal in either CHK state drops straight back
  // to the stable state, so qualification always restarts from scratch and
  // cnt stops at CNT_MAX before it could wrap.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    case (state)
      LOW: begin
        if (s2) begin
          state_nxt = RISE_CHK;
          cnt_nxt   = CW'(1);
        end
      end
      RISE_CHK: begin
        if (!s2) begin
          state_nxt = LOW;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HIGH: begin
        if (!s2) begin
          state_nxt = FALL_CHK;
          cnt_nxt   = CW'(1);
        end
      end
      FALL_CHK: begin
        if (s2) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt   = LOW;
          cnt_nxt     = '0;
          release_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = LOW;
        cnt_nxt   = '0;
      end
    endcase
  end

`ifdef SW_DEBOUNCE_REPEAT_EN
  localparam int RW = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
  localparam logic [RW-1:0] RDELAY_MAX  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPERIOD_MAX = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rcnt;
  logic [RW-1:0] rcnt_nxt;
  logic          rfirst;
  logic          rfirst_nxt;

  // Auto-repeat timer. It restarts only on a fresh press; a bounce into
  // FALL_CHK freezes it, and a return to HIGH resumes from the same count.
  // rfirst selects the longer initial delay until the first repeat fires.
  always_comb begin
    rcnt_nxt   = rcnt;
    rfirst_nxt = rfirst;
    rep_fire   = 1'b0;
    if (press_nxt) begin
      rcnt_nxt   = '0;
      rfirst_nxt = 1'b1;
    end else if (state == HIGH && s2) begin
      if (rcnt == (rfirst ? RDELAY_MAX : RPERIOD_MAX)) begin
        rep_fire   = 1'b1;
        rcnt_nxt   = '0;
        rfirst_nxt = 1'b0;
      end else begin
        rcnt_nxt = rcnt + 1'b1;
      end
    end
  end

  // Repeat timer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcnt   <= '0;
      rfirst <= 1'b1;
    end else begin
      rcnt   <= rcnt_nxt;
      rfirst <= rfirst_nxt;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  // Synchroniser, FSM state and registered outputs. The outputs are taken
  // from the next-state decode so they change on the same edge as the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      state      <= LOW;
      cnt        <= '0;
      sw_level   <= 1'b0;
      sw_press   <= 1'b0;
      sw_release <= 1'b0;
    end else begin
      s1         <= sw_raw;
      s2         <= s1;
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      sw_level   <= state_nxt[1];
      sw_press   <= press_nxt | rep_fire;
      sw_release <= release_nxt;
    end
  end

endmodule

// File: rtl/sw_debounce.sv
// sw_debounce -- debounced, synchronised push-switch inputs for the LED
// blink logic. One independent sw_debounce_chan per switch pin.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   sw_raw      [N_SW] raw switch pins, 1 = pressed
//   sw_level    [N_SW] debounced levels
//   sw_press    [N_SW] one-cycle press pulses (plus auto-repeat if enabled)
//   sw_release  [N_SW] one-cycle release pulses
//
// Build option: SW_DEBOUNCE_REPEAT_EN enables auto-repeat in every channel.
module sw_debounce
  import icestick_pkg::*;
#(
  parameter int N_SW            = 4,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = 6000000,
  parameter int REPEAT_PERIOD   = 1200000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_SW-1:0] sw_raw,
  output logic [N_SW-1:0] sw_level,
  output logic [N_SW-1:0] sw_press,
  output logic [N_SW-1:0] sw_release
);

  for (genvar i = 0; i < N_SW; i++) begin : g_chan
    sw_debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .sw_raw     (sw_raw[i]),
      .sw_level   (sw_level[i]),
      .sw_press   (sw_press[i]),
      .sw_release (sw_release[i])
    );
  end

endmodule
